piso_jk_tx: RTL and testbench
=============================

# piso_jk_tx

Parallel-in, serial-out transmitter: the sending end of the 4-bit serial link whose receiving end is the JK-flip-flop SISO shift register. It accepts a parallel word through a valid/ready load handshake and shifts it out MSB-first, one bit per `clk`. After WIDTH receiver clocks the receiver's parallel register equals the loaded word. Shift stages are built from JK flip-flops so the transmitter and receiver share cell style.

## Interface
Parameters:
- `WIDTH`, default 4: word length in bits; legal range 2..32.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `din`  in  WIDTH  parallel word; sampled only on a load handshake.
- `load_valid`  in  1  source has a word on `din`.
- `load_ready`  out  1  transmitter can accept a word this cycle.
- `sout`  out  1  serial data to the receiver's `sin`.
- `sout_valid`  out  1  `sout` carries a payload bit this cycle.
- `last`  out  1  high during the final bit (bit 0) of a word.
- `busy`  out  1  FSM is in SHIFT.

## Operation
- FSM states are IDLE and SHIFT. Reset state is IDLE.
- A handshake occurs on a rising edge where `load_valid && load_ready`. On that edge: `shreg <= din`, `cnt <= 0`, state <= SHIFT.
- In SHIFT:
  - `sout = shreg[WIDTH-1]`, `sout_valid = 1`.
  - Each edge shifts `shreg` left, fills the LSB with 0, and increments `cnt`.
- `last = busy && (cnt == WIDTH-1)`.
- On the edge ending the `last` cycle:
  - With a handshake: reload and stay in SHIFT. This gives gapless back-to-back words.
  - Without a handshake: go to IDLE.
- `load_ready = !rst && (state == IDLE || last)`. A `load_valid` held mid-word is not accepted. `din` changes mid-word have no effect.
- In IDLE, `sout = 0` and `sout_valid = 0`. A receiver clocked while idle therefore shifts in zeros, consistent with its reset value.
- Each shift stage is a JK flip-flop with J = next bit and K = ~next bit, so it acts as a D-type. The async reset clears every stage to 0.
- `cnt` width is `$clog2(WIDTH)`. It never exceeds WIDTH-1 and wraps only by reload.

## Timing
- Reset values (immediately on `rst` assertion, no clock needed): `sout=0`, `sout_valid=0`, `last=0`, `busy=0`, `load_ready=0`. After `rst` deasserts, `load_ready=1` combinationally.
- Reset mid-word aborts the word immediately. No partial completion; the FSM returns to IDLE and the word is dropped.
- Latency from a handshake at edge k:
  - bit `din[WIDTH-1-i]` is on `sout` during the cycle after edge k+i, for i = 0..WIDTH-1;
  - `last` is high during the cycle after edge k+WIDTH-1.
- A receiver sampling at edges k+1..k+WIDTH holds `din` after edge k+WIDTH.
- Throughput: one word per WIDTH cycles when `load_valid` stays high.
- `load_ready`, `last` and `sout` are combinational from registered state and `rst` only. They do not depend combinationally on `load_valid` or `din`.

## Structure
- Package `piso_pkg`: state typedef (`ST_IDLE`, `ST_SHIFT`) and the default width constant `PISO_WIDTH_DEF = 4`.
- Sub-module `jk_ff` (inputs `clk`, `rst`, `j`, `k`; output `q`): one instance per shift stage, generated WIDTH times. The top level holds the FSM, counter and handshake logic.

## Test plan
- Reset check: assert `rst` mid-simulation with no clock edge. `sout`, `sout_valid`, `last`, `busy` and `load_ready` must all read 0 at once. Release `rst`; `load_ready` must read 1.
- Single word: load `din=4'b1011` → `sout` reads 1, 0, 1, 1 on consecutive cycles with `sout_valid=1`, and `last` is high only on the 4th cycle. A reference SISO receiver fed from `sout` holds `4'b1011` after 4 edges.
- Back-to-back words: hold `load_valid=1` with `4'hA` then `4'h5` → stream 1,0,1,0,0,1,0,1 with no idle gap. `load_ready` is high only on the two `last` cycles after the first accept, and then again after the second word completes.
- Mid-word load: assert `load_valid` with `din=4'hF` during bit 1 of word `4'h0` → `load_ready=0` and the stream stays 0,0,0,0. `4'hF` is accepted on the `last` cycle.
- Reset mid-word: load `4'hF`, assert `rst` after 2 bits → `sout=0` immediately and the FSM is in IDLE. The next load of `4'h9` transmits 1,0,0,1 cleanly.
- Parameter sweep: WIDTH=8 with `din=8'hC3` → 8-bit MSB-first stream 1,1,0,0,0,0,1,1, and `last` is high on the 8th bit.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO JK transmitter.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int PISO_WIDTH_DEF = 4;

endpackage

// File: rtl/jk_ff.sv
// JK flip-flop with asynchronous active-high clear.
module jk_ff (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      unique case ({j, k})
        2'b00:   q <= q;
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/piso_jk_tx.sv
// Parallel-in serial-out transmitter, MSB first, JK shift stages.
module piso_jk_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic            hs;

  assign busy       = (state_q == ST_SHIFT);
  assign last       = busy && (cnt_q == CNT_LAST);
  assign load_ready = !rst && (!busy || last);
  assign hs         = load_valid && load_ready;
  assign sout       = busy && shreg_q[WIDTH-1];
  assign sout_valid = busy;

  always_comb begin
    shreg_d = shreg_q;
    if (hs) begin
      shreg_d = din;
    end else if (busy) begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  // J = next bit, K = its complement: each stage behaves as a D flop.
  for (genvar g = 0; g < WIDTH; g++) begin : g_stage
    jk_ff u_stage (
      .clk (clk),
      .rst (rst),
      .j   (shreg_d[g]),
      .k   (~shreg_d[g]),
      .q   (shreg_q[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (hs) begin
      state_q <= ST_SHIFT;
      cnt_q   <= '0;
    end else if (busy) begin
      if (last) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_piso_jk_tx.sv
// Self-checking bench for piso_jk_tx (WIDTH=4 and WIDTH=8).
module tb_piso_jk_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [3:0] din4 = '0;
  logic       lv4 = 1'b0;
  logic       lr4, so4, sv4, last4, busy4;

  logic [7:0] din8 = '0;
  logic       lv8 = 1'b0;
  logic       lr8, so8, sv8, last8, busy8;

  logic [3:0] rx4;
  logic [7:0] rx8;

  logic [1:0] q4[$];
  logic [1:0] q8[$];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] din;
    logic [3:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  piso_jk_tx #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .din(din4), .load_valid(lv4),
    .load_ready(lr4), .sout(so4), .sout_valid(sv4),
    .last(last4), .busy(busy4)
  );

  piso_jk_tx #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .din(din8), .load_valid(lv8),
    .load_ready(lr8), .sout(so8), .sout_valid(sv8),
    .last(last8), .busy(busy8)
  );

  // reference SISO receivers
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rx4 <= '0;
      rx8 <= '0;
    end else begin
      rx4 <= {rx4[2:0], so4};
      rx8 <= {rx8[6:0], so8};
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (sv4) begin
        if (q4.size() == 0) begin
          chk("unexpected_bit4", 1, 0);
        end else begin
          logic [1:0] e;
          e = q4.pop_front();
          chk("sout4", so4, e[1]);
          chk("last4", last4, e[0]);
        end
      end else begin
        chk("idle_sout4", so4, 0);
        chk("idle_last4", last4, 0);
      end
      if (sv8) begin
        if (q8.size() == 0) begin
          chk("unexpected_bit8", 1, 0);
        end else begin
          logic [1:0] e;
          e = q8.pop_front();
          chk("sout8", so8, e[1]);
          chk("last8", last8, e[0]);
        end
      end
    end
  end

  task automatic push4(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) q4.push_back({v[i], i == 0});
  endtask

  task automatic push8(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) q8.push_back({v[i], i == 0});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // returns in the cycle after the accepting edge; leaves load_valid high
  task automatic load4(input logic [3:0] v);
    bit done = 0;
    lv4  = 1'b1;
    din4 = v;
    for (int t = 0; t < 20 && !done; t++) begin
      if (lr4) begin
        push4(v);
        done = 1;
      end
      step();
    end
    if (!done) chk("load4_timeout", 0, 1);
  endtask

  initial begin
    vecs[0] = '{4'b1011, 4'b1011};
    vecs[1] = '{4'b0000, 4'b0000};
    vecs[2] = '{4'b1111, 4'b1111};
    vecs[3] = '{4'b0110, 4'b0110};
    vecs[4] = '{4'b1001, 4'b1001};

    #2;
    chk("rst_sout", so4, 0);
    chk("rst_valid", sv4, 0);
    chk("rst_last", last4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_ready", lr4, 0);
    step();
    rst = 1'b0;
    #1;
    chk("ready_after_rst", lr4, 1);
    step();

    // reset while idle, no clock edge
    #2;
    rst = 1'b1;
    #1;
    chk("idle_rst_ready", lr4, 0);
    chk("idle_rst_busy", busy4, 0);
    #1;
    rst = 1'b0;
    #1;
    chk("idle_rst_release", lr4, 1);
    step();

    // table-driven single words
    foreach (vecs[n]) begin
      load4(vecs[n].din);
      lv4 = 1'b0;
      chk("busy_first", busy4, 1);
      for (int c = 0; c < 4; c++) step();
      chk("rx4_word", rx4, vecs[n].exp_rx);
      chk("idle_after", busy4, 0);
    end

    // back-to-back A then 5, valid held
    load4(4'hA);
    push4(4'h5);
    din4 = 4'h5;
    for (int c = 0; c < 8; c++) begin
      chk("b2b_busy", busy4, 1);
      chk("b2b_ready", lr4, (c == 3 || c == 7));
      if (c == 7) lv4 = 1'b0;
      step();
    end
    chk("b2b_end_busy", busy4, 0);
    chk("b2b_end_ready", lr4, 1);
    chk("b2b_rx", rx4, 4'h5);
    step();

    // load_valid held mid-word is ignored until last
    load4(4'h0);
    lv4 = 1'b0;
    step();
    lv4  = 1'b1;
    din4 = 4'hF;
    chk("mid_ready1", lr4, 0);
    step();
    chk("mid_ready2", lr4, 0);
    step();
    chk("mid_ready_last", lr4, 1);
    chk("mid_last", last4, 1);
    push4(4'hF);
    step();
    lv4 = 1'b0;
    for (int c = 0; c < 4; c++) step();
    chk("mid_rx", rx4, 4'hF);

    // reset mid-word drops the word
    load4(4'hF);
    lv4 = 1'b0;
    step();
    step();
    #2;
    rst = 1'b1;
    q4.delete();
    #1;
    chk("midrst_sout", so4, 0);
    chk("midrst_valid", sv4, 0);
    chk("midrst_busy", busy4, 0);
    chk("midrst_ready", lr4, 0);
    step();
    rst = 1'b0;
    #1;
    chk("midrst_release", lr4, 1);
    load4(4'h9);
    lv4 = 1'b0;
    for (int c = 0; c < 4; c++) step();
    chk("after_rst_rx", rx4, 4'h9);

    // WIDTH=8
    lv8  = 1'b1;
    din8 = 8'hC3;
    #0;
    chk("w8_ready", lr8, 1);
    push8(8'hC3);
    step();
    lv8 = 1'b0;
    for (int c = 0; c < 7; c++) begin
      chk("w8_last", last8, (c == 7) ? 1 : 0);
      step();
    end
    chk("w8_last8th", last8, 1);
    step();
    chk("w8_rx", rx8, 8'hC3);
    chk("w8_idle", busy8, 0);

    step();
    chk("q4_drained", q4.size(), 0);
    chk("q8_drained", q8.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
